// File: rtl/sw_debounce8.sv
// sw_debounce8: eight-channel switch debouncer.
// Each raw switch bit is synchronized through two flops. The debounced output
// bit follows the synchronized level only after that level has differed from it
// for STABLE_CYCLES consecutive enabled cycles.
// A startup counter raises valid once the synchronizers and counters have had
// time to settle after reset.
// Optional feature macro: SW_DEBOUNCE8_EDGE_EN
//   defined   -> registered rise/fall/changed pulses are generated.
//   undefined -> rise/fall/changed are tied to 0 and no edge registers exist.
module sw_debounce8 #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_in,
  input  logic       en,
  output logic [7:0] sw_out,
  output logic       valid,
  output logic       changed,
  output logic [7:0] rise,
  output logic [7:0] fall
);

  // Count value at which a differing bit is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  // One extra bit so STABLE_CYCLES+2 always fits, even at the top of the range.
  localparam logic [CNT_W:0]   VALID_AT = (CNT_W + 1)'(STABLE_CYCLES + 2);

  logic [7:0]       s1_q, s1_d;
  logic [7:0]       s2_q, s2_d;
  logic [7:0]       sw_out_q, sw_out_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [CNT_W:0]   start_cnt_q, start_cnt_d;
  logic             valid_q, valid_d;

  // Synchronizer, per-bit stability counters and debounced output next state.
  always_comb begin
    s1_d     = sw_in;
    s2_d     = s1_q;
    sw_out_d = sw_out_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (en) begin
        if (s2_q[i] != sw_out_q[i]) begin
          // The >= compare also keeps the counter from ever wrapping.
          if (cnt_q[i] >= CNT_LAST) begin
            sw_out_d[i] = s2_q[i];
            cnt_d[i]    = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Startup blanking: count enabled cycles until VALID_AT, then hold.
  always_comb begin
    start_cnt_d = start_cnt_q;
    if (en && (start_cnt_q != VALID_AT)) begin
      start_cnt_d = start_cnt_q + (CNT_W + 1)'(1);
    end
    valid_d = valid_q | (start_cnt_d == VALID_AT);
  end

  // Core state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      sw_out_q    <= '0;
      start_cnt_q <= '0;
      valid_q     <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      sw_out_q    <= sw_out_d;
      start_cnt_q <= start_cnt_d;
      valid_q     <= valid_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_out = sw_out_q;
  assign valid  = valid_q;

`ifdef SW_DEBOUNCE8_EDGE_EN
  logic [7:0] rise_q, rise_d;
  logic [7:0] fall_q, fall_d;
  logic       changed_q, changed_d;

  // Edge pulses line up with the cycle the new sw_out value first appears.
  always_comb begin
    rise_d    = sw_out_d & ~sw_out_q;
    fall_d    = ~sw_out_d & sw_out_q;
    changed_d = |(rise_d | fall_d);
  end

  // Edge pulse registers; reset clears them so reset never reports an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce8.sv
// Bench for sw_debounce8 at STABLE_CYCLES=4. A vector table holds per-cycle
// inputs and the outputs expected after that clock edge; expectations are queued
// when a vector is driven and popped when the outputs are sampled 1ns later.
module tb_sw_debounce8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw_in;
  logic       en;
  logic [7:0] sw_out;
  logic       valid;
  logic       changed;
  logic [7:0] rise;
  logic [7:0] fall;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] sw;
    logic [7:0] eo;
    logic       ev;
    logic [7:0] er;
    logic [7:0] ef;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] eo;
    logic       ev;
    logic [7:0] er;
    logic [7:0] ef;
    logic       ec;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  sw_debounce8 #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw_in   (sw_in),
    .en      (en),
    .sw_out  (sw_out),
    .valid   (valid),
    .changed (changed),
    .rise    (rise),
    .fall    (fall)
  );

  always #5 clk = ~clk;

  task automatic addn(input int n, input logic r, input logic e, input logic [7:0] sw,
                      input logic [7:0] eo, input logic ev,
                      input logic [7:0] er, input logic [7:0] ef);
    vec_t v;
    v.rst = r; v.en = e; v.sw = sw; v.eo = eo; v.ev = ev; v.er = er; v.ef = ef;
    for (int j = 0; j < n; j++) vecs.push_back(v);
  endtask

  task automatic chk8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    exp_t x;
    rst = 1'b1; en = 1'b1; sw_in = 8'h00;

    // A: reset with all switches high -> sw_out FF after edge 6, valid from edge 6
    addn(1, 1, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
    addn(5, 0, 1, 8'hFF, 8'h00, 0, 8'h00, 8'h00);
    addn(1, 0, 1, 8'hFF, 8'hFF, 1, 8'hFF, 8'h00);
    addn(2, 0, 1, 8'hFF, 8'hFF, 1, 8'h00, 8'h00);
    // B: reset to all-low, then a 3-cycle glitch on bit 3 is rejected
    addn(1, 1, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    addn(5, 0, 1, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    addn(2, 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    addn(3, 0, 1, 8'h08, 8'h00, 1, 8'h00, 8'h00);
    addn(5, 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    // B2: a 4-cycle pulse on bit 3 is just long enough, then falls back
    addn(4, 0, 1, 8'h08, 8'h00, 1, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h00, 8'h08, 1, 8'h08, 8'h00);
    addn(3, 0, 1, 8'h00, 8'h08, 1, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h08);
    addn(1, 0, 1, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    // C: reach 81, then 81->01 with en low for edges k+3..k+5
    addn(5, 0, 1, 8'h81, 8'h00, 1, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h81, 8'h81, 1, 8'h81, 8'h00);
    addn(1, 0, 1, 8'h81, 8'h81, 1, 8'h00, 8'h00);
    addn(3, 0, 1, 8'h01, 8'h81, 1, 8'h00, 8'h00);
    addn(3, 0, 0, 8'h01, 8'h81, 1, 8'h00, 8'h00);
    addn(2, 0, 1, 8'h01, 8'h81, 1, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h01, 8'h01, 1, 8'h00, 8'h80);
    addn(1, 0, 1, 8'h01, 8'h01, 1, 8'h00, 8'h00);
    // D: bit 2 count reaches 2, reset interrupts it, fresh full latency after
    addn(4, 0, 1, 8'h05, 8'h01, 1, 8'h00, 8'h00);
    addn(1, 1, 1, 8'h05, 8'h00, 0, 8'h00, 8'h00);
    addn(5, 0, 1, 8'h05, 8'h00, 0, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h05, 8'h05, 1, 8'h05, 8'h00);
    addn(1, 0, 1, 8'h05, 8'h05, 1, 8'h00, 8'h00);
    // E: bits change at staggered times and update independently
    addn(2, 0, 1, 8'h07, 8'h05, 1, 8'h00, 8'h00);
    addn(3, 0, 1, 8'h03, 8'h05, 1, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h03, 8'h07, 1, 8'h02, 8'h00);
    addn(1, 0, 1, 8'h03, 8'h07, 1, 8'h00, 8'h00);
    addn(1, 0, 1, 8'h03, 8'h03, 1, 8'h00, 8'h04);
    addn(1, 0, 1, 8'h03, 8'h03, 1, 8'h00, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      en    = vecs[i].en;
      sw_in = vecs[i].sw;
      x.idx = i;
      x.eo  = vecs[i].eo;
      x.ev  = vecs[i].ev;
`ifdef SW_DEBOUNCE8_EDGE_EN
      x.er  = vecs[i].er;
      x.ef  = vecs[i].ef;
      x.ec  = |(vecs[i].er | vecs[i].ef);
`else
      x.er  = 8'h00;
      x.ef  = 8'h00;
      x.ec  = 1'b0;
`endif
      sb.push_back(x);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard vec %0d: got empty queue expected entry", i);
      end else begin
        x = sb.pop_front();
        chk8("sw_out",  x.idx, sw_out, x.eo);
        chk8("valid",   x.idx, {7'd0, valid}, {7'd0, x.ev});
        chk8("rise",    x.idx, rise, x.er);
        chk8("fall",    x.idx, fall, x.ef);
        chk8("changed", x.idx, {7'd0, changed}, {7'd0, x.ec});
      end
    end

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
